grid_scan_tracker: RTL

- Successor to the combinational grid-line detector for the 2048 VGA display.
- Tracks the scan position through an N x N board with counters, so no per-line comparators are needed. Board size, cell size, line width and origin are parametrised.
- Reports grid-line hits, cell interior hits, the cell row/column and the pixel offset inside the cell.
- Generates a frame-based blinking highlight for one selected cell. Sits between the VGA timing generator and the tile/colour mux.

---
 rtl/grid_scan_tracker.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/grid_scan_tracker.sv
// Scan-position tracker for the VGA game board. Follows the raster with
// per-axis position/cell counters instead of per-line comparators, reports
// grid-line and cell-interior hits with cell coordinates and in-cell offsets,
// and produces a frame-rate blinking highlight for one selected cell.
module grid_scan_tracker #(
  parameter  int N            = 4,
  parameter  int CELL_W       = 102,
  parameter  int LINE_W       = 8,
  parameter  int X0           = 16,
  parameter  int Y0           = 16,
  parameter  int COORD_W      = 10,
  parameter  int BLINK_FRAMES = 30,
  localparam int PITCH        = CELL_W + LINE_W,
  localparam int PW           = $clog2(PITCH),
  localparam int CW           = $clog2(N + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pixel_en,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               frame_start,
  input  logic [CW-1:0]      sel_row,
  input  logic [CW-1:0]      sel_col,
  input  logic               blink_en,
  output logic               in_grid,
  output logic               in_cell,
  output logic [CW-1:0]      cell_row,
  output logic [CW-1:0]      cell_col,
  output logic [PW-1:0]      cell_px,
  output logic [PW-1:0]      cell_py,
  output logic               highlight
);

  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [COORD_W-1:0] X0_C       = COORD_W'(X0);
  localparam logic [COORD_W-1:0] Y0_C       = COORD_W'(Y0);
  localparam logic [PW-1:0]      PITCH_LAST = PW'(PITCH - 1);
  localparam logic [PW-1:0]      LINE_LAST  = PW'(LINE_W - 1);
  localparam logic [PW-1:0]      LINE_P     = PW'(LINE_W);
  localparam logic [CW-1:0]      CELL_N     = CW'(N);
  localparam logic [FW-1:0]      FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0] xPos_q, xPos_d, yPos_q, yPos_d;
  logic [CW-1:0] xCell_q, xCell_d, yCell_q, yCell_d;
  logic          xAct_q, xAct_d, yAct_q, yAct_d;
  logic [FW-1:0] frameCnt_q, frameCnt_d;
  logic          blinkPhase_q, blinkPhase_d;

  logic act, xLine, yLine, cellHit;

  // Next-state: horizontal/vertical counters advance per pixel, blink per frame
  always_comb begin
    xPos_d       = xPos_q;
    xCell_d      = xCell_q;
    xAct_d       = xAct_q;
    yPos_d       = yPos_q;
    yCell_d      = yCell_q;
    yAct_d       = yAct_q;
    frameCnt_d   = frameCnt_q;
    blinkPhase_d = blinkPhase_q;

    if (pixel_en) begin
      if (x == X0_C) begin
        xPos_d  = '0;
        xCell_d = '0;
        xAct_d  = 1'b1;
      end else if (xAct_q) begin
        if (xCell_q == CELL_N && xPos_q == LINE_LAST) begin
          xAct_d = 1'b0;
        end else if (xPos_q == PITCH_LAST) begin
          xPos_d  = '0;
          xCell_d = xCell_q + CW'(1);
        end else begin
          xPos_d = xPos_q + PW'(1);
        end
      end

      // The left grid edge is the one pixel per line where the row advances
      if (x == X0_C) begin
        if (y == Y0_C) begin
          yPos_d  = '0;
          yCell_d = '0;
          yAct_d  = 1'b1;
        end else if (y < Y0_C) begin
          yAct_d = 1'b0;
        end else if (yAct_q) begin
          if (yCell_q == CELL_N && yPos_q == LINE_LAST) begin
            yAct_d = 1'b0;
          end else if (yPos_q == PITCH_LAST) begin
            yPos_d  = '0;
            yCell_d = yCell_q + CW'(1);
          end else begin
            yPos_d = yPos_q + PW'(1);
          end
        end
      end
    end

    if (frame_start) begin
      if (!blink_en) begin
        frameCnt_d   = '0;
        blinkPhase_d = 1'b1;
      end else if (frameCnt_q == FRAME_LAST) begin
        frameCnt_d   = '0;
        blinkPhase_d = ~blinkPhase_q;
      end else begin
        frameCnt_d = frameCnt_q + FW'(1);
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      xPos_q       <= '0;
      xCell_q      <= '0;
      xAct_q       <= 1'b0;
      yPos_q       <= '0;
      yCell_q      <= '0;
      yAct_q       <= 1'b0;
      frameCnt_q   <= '0;
      blinkPhase_q <= 1'b1;
    end else begin
      xPos_q       <= xPos_d;
      xCell_q      <= xCell_d;
      xAct_q       <= xAct_d;
      yPos_q       <= yPos_d;
      yCell_q      <= yCell_d;
      yAct_q       <= yAct_d;
      frameCnt_q   <= frameCnt_d;
      blinkPhase_q <= blinkPhase_d;
    end
  end

  // Output decode from the tracked position of the last sampled pixel
  always_comb begin
    act       = xAct_q & yAct_q;
    xLine     = (xPos_q < LINE_P);
    yLine     = (yPos_q < LINE_P);
    cellHit   = act & ~xLine & ~yLine;
    in_grid   = act & (xLine | yLine);
    in_cell   = cellHit;
    cell_col  = act ? xCell_q : '0;
    cell_row  = act ? yCell_q : '0;
    cell_px   = cellHit ? (xPos_q - LINE_P) : '0;
    cell_py   = cellHit ? (yPos_q - LINE_P) : '0;
    highlight = cellHit & (yCell_q == sel_row) & (xCell_q == sel_col) & blinkPhase_q;
  end

endmodule
